// File: rtl/prbs_pkg.sv
// Shared definitions for the x^4+x^3+1 sequence checker: FSM states, taps and
// the reference pattern produced from seed 0001.
package prbs_pkg;

   typedef enum logic [1:0] {
      ST_ACQ    = 2'd0,
      ST_SYNC   = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   localparam int HIST_W  = 4;
   localparam int TAP_HI  = 3;
   localparam int TAP_LO  = 2;
   localparam int SEQ_LEN = 15;

   // Bit SEQ_LEN-1 is the first bit transmitted after seeding with 0001.
   localparam logic [SEQ_LEN-1:0] SEED_PATTERN = 15'b000100110101111;

   function automatic logic predict_bit(input logic [HIST_W-1:0] hist);
      return hist[TAP_HI] ^ hist[TAP_LO];
   endfunction

endpackage

// File: rtl/prbs_predict.sv
// Received-bit history register with next-bit prediction and compare.
// The history shifts in the received bit, so the predictor self-synchronises.
module prbs_predict
   import prbs_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              sin,
   input  logic              sin_valid,
   output logic [HIST_W-1:0] hist,
   output logic [HIST_W-1:0] hist_next,
   output logic              mismatch,
   output logic              hist_zero
);

   logic [HIST_W-1:0] hist_q;
   logic [HIST_W-1:0] hist_d;

   always_comb begin
      // NOTE: assign a default before any condition so no path leaves the
      // signal unassigned, which would infer a latch.
      hist_d = hist_q;
      if (sin_valid) begin
         hist_d = {hist_q[HIST_W-2:0], sin};
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: registers use non-blocking assignment so every flop samples
      // pre-edge values regardless of statement order.
      if (rst) begin
         hist_q <= '0;
      end else begin
         hist_q <= hist_d;
      end
   end

   assign hist      = hist_q;
   assign hist_next = hist_d;
   assign mismatch  = sin ^ predict_bit(hist_q);
   assign hist_zero = (hist_q == '0);

endmodule

// File: rtl/prbs_checker.sv
// Serial PRBS checker: acquires the 4-bit sequence, locks after a run of good
// predictions, then flags and counts bit errors until lock is lost.
module prbs_checker
   import prbs_pkg::*;
#(
   parameter int LOCK_CNT = 8,
   parameter int LOSS_CNT = 3,
   parameter int ERR_W    = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             SIN,
   input  logic             SIN_VALID,
   input  logic             CLR,
   output logic             LOCKED,
   output logic             BIT_ERR,
   output logic [ERR_W-1:0] ERR_COUNT,
   output logic             STUCK,
   output logic [3:0]       HIST
);

   localparam int MATCH_W = $clog2(LOCK_CNT + 1);
   localparam int MISS_W  = $clog2(LOSS_CNT + 1);

   state_t             state_q,     state_d;
   logic [1:0]         fill_q,      fill_d;
   logic [MATCH_W-1:0] match_run_q, match_run_d;
   logic [MISS_W-1:0]  miss_run_q,  miss_run_d;
   logic [ERR_W-1:0]   err_count_q, err_count_d;
   logic               bit_err_q,   bit_err_d;
   logic               stuck_q,     stuck_d;

   logic [HIST_W-1:0]  hist;
   logic [HIST_W-1:0]  hist_next;
   logic               mismatch;
   logic               hist_zero;
   logic               err_inc;

   prbs_predict u_predict (
      .clk       (CLK),
      .rst       (RST),
      .sin       (SIN),
      .sin_valid (SIN_VALID),
      .hist      (hist),
      .hist_next (hist_next),
      .mismatch  (mismatch),
      .hist_zero (hist_zero)
   );

   always_comb begin
      state_d     = state_q;
      fill_d      = fill_q;
      match_run_d = match_run_q;
      miss_run_d  = miss_run_q;
      err_count_d = err_count_q;
      bit_err_d   = 1'b0;
      err_inc     = 1'b0;

      if (SIN_VALID) begin
         case (state_q)
            ST_ACQ: begin
               if (fill_q == 2'd3) begin
                  state_d     = ST_SYNC;
                  fill_d      = '0;
                  match_run_d = '0;
               end else begin
                  fill_d = fill_q + 2'd1;
               end
            end
            ST_SYNC: begin
               // An all-zero history predicts zero forever; never count it.
               if (!mismatch && !hist_zero) begin
                  match_run_d = match_run_q + MATCH_W'(1);
                  if (match_run_q == MATCH_W'(LOCK_CNT - 1)) begin
                     state_d    = ST_LOCKED;
                     miss_run_d = '0;
                  end
               end else begin
                  match_run_d = '0;
               end
            end
            ST_LOCKED: begin
               if (mismatch) begin
                  err_inc    = 1'b1;
                  bit_err_d  = 1'b1;
                  miss_run_d = miss_run_q + MISS_W'(1);
                  if (miss_run_q == MISS_W'(LOSS_CNT - 1)) begin
                     state_d = ST_ACQ;
                     fill_d  = '0;
                  end
               end else begin
                  miss_run_d = '0;
               end
               if (hist_next == '0) begin
                  state_d = ST_ACQ;
                  fill_d  = '0;
               end
            end
            default: state_d = ST_ACQ;
         endcase
      end

      // A clear coinciding with a counted error leaves exactly that error.
      if (CLR) begin
         err_count_d = err_inc ? ERR_W'(1) : '0;
      end else if (err_inc && (err_count_q != '1)) begin
         err_count_d = err_count_q + ERR_W'(1);
      end

      stuck_d = (state_d != ST_ACQ) && (hist_next == '0);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= ST_ACQ;
         fill_q      <= '0;
         match_run_q <= '0;
         miss_run_q  <= '0;
         err_count_q <= '0;
         bit_err_q   <= 1'b0;
         stuck_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         fill_q      <= fill_d;
         match_run_q <= match_run_d;
         miss_run_q  <= miss_run_d;
         err_count_q <= err_count_d;
         bit_err_q   <= bit_err_d;
         stuck_q     <= stuck_d;
      end
   end

   assign LOCKED    = (state_q == ST_LOCKED);
   assign BIT_ERR   = bit_err_q;
   assign ERR_COUNT = err_count_q;
   assign STUCK     = stuck_q;
   assign HIST      = hist;

endmodule

// File: tb/tb_prbs_checker.sv
// Scoreboard bench for prbs_checker: a behavioural model predicts every cycle's
// outputs into a queue; a monitor pops and compares after each clock edge.
module tb_prbs_checker;
   import prbs_pkg::*;

   localparam int LOCK_CNT = 8;
   localparam int LOSS_CNT = 3;
   localparam int ERR_W    = 8;
   localparam int ERR_MAX  = (1 << ERR_W) - 1;
   localparam int M_ACQ    = 0;
   localparam int M_SYNC   = 1;
   localparam int M_LOCKED = 2;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             sin = 1'b0;
   logic             sin_valid = 1'b0;
   logic             clr = 1'b0;
   logic             locked;
   logic             bit_err;
   logic [ERR_W-1:0] err_count;
   logic             stuck;
   logic [3:0]       hist;

   always #5 clk = ~clk;

   prbs_checker #(
      .LOCK_CNT (LOCK_CNT),
      .LOSS_CNT (LOSS_CNT),
      .ERR_W    (ERR_W)
   ) dut (
      .CLK       (clk),
      .RST       (rst),
      .SIN       (sin),
      .SIN_VALID (sin_valid),
      .CLR       (clr),
      .LOCKED    (locked),
      .BIT_ERR   (bit_err),
      .ERR_COUNT (err_count),
      .STUCK     (stuck),
      .HIST      (hist)
   );

   typedef struct packed {
      logic             locked;
      logic             bit_err;
      logic [ERR_W-1:0] err;
      logic             stuck;
      logic [3:0]       hist;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: last four received bits, rx[0] oldest.
   bit rx[$];
   int m_mode, m_fill, m_match, m_miss, m_err;
   bit m_bit_err;

   task automatic model_reset();
      rx = '{1'b0, 1'b0, 1'b0, 1'b0};
      m_mode = M_ACQ; m_fill = 0; m_match = 0; m_miss = 0; m_err = 0;
      m_bit_err = 1'b0;
   endtask

   function automatic bit rx_zero();
      return !(rx[0] | rx[1] | rx[2] | rx[3]);
   endfunction

   task automatic model_step(input bit s, input bit v, input bit c, input bit r);
      bit counted = 1'b0;
      bit pred;
      bit was_locked;
      exp_t e;
      if (r) begin
         model_reset();
      end else begin
         m_bit_err = 1'b0;
         if (v) begin
            pred = rx[0] ^ rx[1];
            was_locked = (m_mode == M_LOCKED);
            if (m_mode == M_ACQ) begin
               m_fill++;
               if (m_fill == 4) begin m_mode = M_SYNC; m_fill = 0; m_match = 0; end
            end else if (m_mode == M_SYNC) begin
               if (s == pred && !rx_zero()) begin
                  m_match++;
                  if (m_match == LOCK_CNT) begin m_mode = M_LOCKED; m_miss = 0; end
               end else begin
                  m_match = 0;
               end
            end else begin
               if (s != pred) begin
                  counted = 1'b1; m_bit_err = 1'b1; m_miss++;
                  if (m_miss == LOSS_CNT) begin m_mode = M_ACQ; m_fill = 0; end
               end else begin
                  m_miss = 0;
               end
            end
            void'(rx.pop_front());
            rx.push_back(s);
            if (was_locked && rx_zero()) begin m_mode = M_ACQ; m_fill = 0; end
         end
         if (c) m_err = counted ? 1 : 0;
         else if (counted && m_err < ERR_MAX) m_err++;
      end
      e.locked  = (m_mode == M_LOCKED);
      e.bit_err = m_bit_err;
      e.err     = ERR_W'(m_err);
      e.stuck   = (m_mode != M_ACQ) && rx_zero();
      e.hist    = {rx[0], rx[1], rx[2], rx[3]};
      sb.push_back(e);
   endtask

   // Transmitter: seed-0001 sequence, independent of any injected errors.
   logic [SEQ_LEN-1:0] pat = SEED_PATTERN;
   int pos = 0;

   function automatic bit tx_bit();
      return pat[SEQ_LEN - 1 - (pos % SEQ_LEN)];
   endfunction

   task automatic send(input bit s, input bit v, input bit c = 1'b0, input bit r = 1'b0);
      @(negedge clk);
      sin = s; sin_valid = v; clr = c; rst = r;
      model_step(s, v, c, r);
      @(posedge clk);
      #1;
      sin_valid = 1'b0; clr = 1'b0; rst = 1'b0;
   endtask

   task automatic send_clean(input bit c = 1'b0);
      send(tx_bit(), 1'b1, c);
      pos++;
   endtask

   task automatic send_flip(input bit c = 1'b0);
      send(!tx_bit(), 1'b1, c);
      pos++;
   endtask

   task automatic do_reset();
      send(1'b0, 1'b0, 1'b0, 1'b1);
      send(1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   // Monitor: compare every cycle that the driver predicted.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("sb_locked",  locked,    e.locked);
            check("sb_bit_err", bit_err,   e.bit_err);
            check("sb_err_cnt", err_count, e.err);
            check("sb_stuck",   stuck,     e.stuck);
            check("sb_hist",    hist,      e.hist);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      model_reset();

      // Reset state
      do_reset();
      check("rst_locked", locked, 0);
      check("rst_bit_err", bit_err, 0);
      check("rst_err_cnt", err_count, 0);
      check("rst_stuck", stuck, 0);
      check("rst_hist", hist, 0);

      // Lock acquisition: 4 fill bits + 8 matches
      pos = 0;
      for (int i = 1; i <= 12; i++) begin
         send_clean();
         if (i == 11) check("lock_not_yet", locked, 0);
      end
      check("lock_at_12", locked, 1);
      for (int i = 0; i < 60; i++) send_clean();
      check("lock_err_cnt", err_count, 0);
      check("lock_hold", locked, 1);

      // Single flipped bit: errors at n, n+3, n+4 (position 12 keeps HIST nonzero)
      while (pos % SEQ_LEN != 12) send_clean();
      send_flip();
      check("single_pulse_n", bit_err, 1);
      for (int i = 1; i <= 8; i++) begin
         send_clean();
         check("single_pulse_k", bit_err, (i == 3 || i == 4) ? 1 : 0);
      end
      check("single_err_cnt", err_count, 3);
      check("single_locked", locked, 1);

      // Loss of lock: three consecutive flips at position 9
      while (pos % SEQ_LEN != 9) send_clean();
      send(1'b0, 1'b0, 1'b1);
      check("clr_alone", err_count, 0);
      send_flip();
      send_flip();
      check("loss_still_locked", locked, 1);
      send_flip();
      check("loss_dropped", locked, 0);
      check("loss_err_cnt", err_count, 3);
      for (int i = 1; i <= 12; i++) begin
         send_clean();
         if (i == 11) check("relock_not_yet", locked, 0);
      end
      check("relock_at_12", locked, 1);

      // Degenerate all-zero input
      do_reset();
      for (int k = 1; k <= 20; k++) begin
         send(1'b0, 1'b1);
         check("stuck_flag", stuck, (k >= 4) ? 1 : 0);
         check("stuck_no_lock", locked, 0);
      end

      // Gapped valid: one valid bit every third cycle
      do_reset();
      pos = 0;
      for (int k = 1; k <= 32; k++) begin
         send(1'($urandom), 1'b0);
         send(1'($urandom), 1'b0);
         send_clean();
         if (k == 11) check("gap_not_yet", locked, 0);
         if (k == 12) check("gap_lock_12", locked, 1);
      end
      check("gap_err_cnt", err_count, 0);

      // CLR coinciding with a counted mismatch
      while (pos % SEQ_LEN != 12) send_clean();
      send_flip();
      for (int i = 0; i < 5; i++) send_clean();
      while (pos % SEQ_LEN != 12) send_clean();
      send_flip(1'b1);
      check("clr_with_err", err_count, 1);

      // Randomised traffic: gaps, flips, occasional clear and reset
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 299) == 0) begin
            send(1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
         end else if ($urandom_range(0, 3) == 0) begin
            send(1'($urandom), 1'b0, ($urandom_range(0, 49) == 0));
         end else if ($urandom_range(0, 11) == 0) begin
            send_flip($urandom_range(0, 49) == 0);
         end else begin
            send_clean($urandom_range(0, 49) == 0);
         end
      end

      // Saturation: 120 isolated flips, 3 counted mismatches each
      for (int f = 0; f < 120; f++) begin
         do begin
            if ($urandom_range(0, 3) == 0) send(1'($urandom), 1'b0);
            send_clean();
         end while (pos % SEQ_LEN != 12);
         send_flip();
      end
      check("sat_err_cnt", err_count, ERR_MAX);
      check("sat_locked", locked, 1);

      // Reset while locked overrides CLR and SIN_VALID
      send(1'($urandom), 1'b1, 1'b1, 1'b1);
      check("rst_lk_locked", locked, 0);
      check("rst_lk_bit_err", bit_err, 0);
      check("rst_lk_err_cnt", err_count, 0);
      check("rst_lk_stuck", stuck, 0);
      check("rst_lk_hist", hist, 0);

      send(1'b0, 1'b0);
      @(negedge clk);
      check("sb_drained", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
